// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative RV32M-style multiply/divide unit with a parametrised
//               data width. Shift-add multiply and restoring divide, one bit
//               per cycle, valid/ready on both sides, result held until taken.
//               Optional macro MULDIV_FAST_MUL_EN replaces the iterative
//               multiply by one combinational multiply at accept.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            MulDivControl,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  busy
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_op;
  logic               r_neg;
  logic               r_special;
  logic [W-1:0]       r_special_val;
  logic [W-1:0]       r_opnd;
  logic [2*W-1:0]     r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_result;

  logic               w_accept, w_is_div, w_a_signed, w_b_signed;
  logic               w_a_neg, w_b_neg, w_div0, w_ovf, w_fast, w_special, w_res_neg;
  logic [W-1:0]       w_a_mag, w_b_mag, w_special_val, w_fast_val, w_final;
  logic [W:0]         w_mul_sum, w_div_shift;
  logic [W-1:0]       w_div_sub;
  logic               w_div_ge;
  logic [2*W-1:0]     w_mul_next, w_div_next, w_mul_full;
  logic [W-1:0]       w_quo, w_rem;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign Result    = r_result;

  // Operand decode: signedness by funct3, magnitudes, and the corner cases
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_is_div   = MulDivControl[2];
  assign w_a_signed = (!MulDivControl[2] && (MulDivControl[1:0] != 2'b11)) ||
                      (MulDivControl[2] && !MulDivControl[0]);
  assign w_b_signed = (!MulDivControl[2] && !MulDivControl[1]) ||
                      (MulDivControl[2] && !MulDivControl[0]);
  assign w_a_neg    = w_a_signed && SrcA[W-1];
  assign w_b_neg    = w_b_signed && SrcB[W-1];
  assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag    = w_b_neg ? -SrcB : SrcB;
  assign w_div0     = w_is_div && (SrcB == '0);
  assign w_ovf      = w_is_div && !MulDivControl[0] && (SrcA == MOST_NEG) && (&SrcB);
  assign w_special  = w_div0 || w_ovf || w_fast;
  // Remainder takes the dividend's sign, everything else the XOR of both
  assign w_res_neg  = (MulDivControl[2] && MulDivControl[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast_a, w_fast_b, w_fast_prod;
  assign w_fast_a    = {{W{w_a_neg}}, SrcA};
  assign w_fast_b    = {{W{w_b_neg}}, SrcB};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast      = !MulDivControl[2];
  assign w_fast_val  = (MulDivControl[1:0] == 2'b00) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
`else
  assign w_fast      = 1'b0;
  assign w_fast_val  = '0;
`endif

  // Result of any operation that finishes without iterating
  always_comb begin
    w_special_val = '0;
    if (w_fast)      w_special_val = w_fast_val;
    else if (w_div0) w_special_val = MulDivControl[1] ? SrcA : '1;
    else if (w_ovf)  w_special_val = MulDivControl[1] ? '0 : SrcA;
  end

  // One shift-add multiply step and one restoring divide step
  assign w_mul_sum   = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next  = {w_mul_sum, r_prod[W-1:1]};
  assign w_div_shift = {r_prod[2*W-1:W], r_prod[W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[W-1:0] - r_opnd;
  assign w_div_next  = {(w_div_ge ? w_div_sub : w_div_shift[W-1:0]), r_prod[W-2:0], w_div_ge};

  assign w_mul_full  = r_neg ? -r_prod : r_prod;
  assign w_quo       = r_prod[W-1:0];
  assign w_rem       = r_prod[2*W-1:W];

  // Sign fix-up and half selection applied on the transition into DONE
  always_comb begin
    w_final = '0;
    case (r_op)
      3'b000:         w_final = w_mul_full[W-1:0];
      3'b001, 3'b010,
      3'b011:         w_final = w_mul_full[2*W-1:W];
      3'b100, 3'b101: w_final = r_neg ? -w_quo : w_quo;
      default:        w_final = r_neg ? -w_rem : w_rem;
    endcase
    if (r_special) w_final = r_special_val;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; zero-iteration ops spend their single cycle in DIV with the counter at 0
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (in_valid) w_state_nxt = (w_is_div || w_fast) ? S_DIV : S_MUL;
        S_MUL, S_DIV: if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE:       if (out_ready) w_state_nxt = S_IDLE;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands at accept, iterate while busy, register the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= '0;
      r_neg         <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_opnd        <= '0;
      r_prod        <= '0;
      r_cnt         <= '0;
      r_result      <= '0;
    end else if (w_accept) begin
      r_op          <= MulDivControl;
      r_neg         <= w_res_neg;
      r_special     <= w_special;
      r_special_val <= w_special_val;
      r_opnd        <= w_is_div ? w_b_mag : w_a_mag;
      r_prod        <= {{W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_cnt         <= w_special ? '0 : CNT_W'(DATA_WIDTH);
    end else if (!flush && busy) begin
      if (r_cnt == '0) begin
        r_result <= w_final;
      end else begin
        r_prod <= (r_state == S_MUL) ? w_mul_next : w_div_next;
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Self-checking bench for alu_muldiv (DATA_WIDTH = 32). A
//               reference model computes results with plain integer math; a
//               compare process checks handshake, latency and Result each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = LAT;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] res;

  int n_chk = 0, n_pass = 0, cyc = 0;

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MulDivControl(op), .SrcA(a), .SrcB(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .Result(res), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference results from the instruction definitions
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      ps, uy;
    logic [63:0] pu;
    int          sx, sy;
    logic        ovf;
    sx  = x;
    sy  = y;
    uy  = longint'({32'h0, y});
    pu  = {32'h0, x} * {32'h0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: return pu[31:0];
      3'd1: begin ps = longint'(sx) * longint'(sy); return ps[63:32]; end
      3'd2: begin ps = longint'(sx) * uy; return ps[63:32]; end
      3'd3: return pu[63:32];
      3'd4: if (y == 0) return '1; else if (ovf) return x; else return sx / sy;
      3'd5: if (y == 0) return '1; else return x / y;
      3'd6: if (y == 0) return x; else if (ovf) return '0; else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    if (!o[2]) return MLAT;
    return LAT;
  endfunction

  typedef struct { logic [W-1:0] exp; int acc; int lat; } item_t;
  item_t q[$];
  int    el;

  // Compare process: every cycle, outputs must match the model's view of the unit
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", res, '0);
      chk("rst_in_ready", in_ready, 1'b1);
      q.delete();
    end else if (q.size() == 0) begin
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_in_ready", in_ready, 1'b1);
      if (in_valid && !flush)
        q.push_back('{exp: model(op, a, b), acc: cyc + 1, lat: model_lat(op, a, b)});
    end else begin
      el = cyc - q[0].acc;
      chk("run_in_ready", in_ready, 1'b0);
      if (el < q[0].lat) begin
        chk("run_out_valid", out_valid, 1'b0);
        if (q[0].lat > 1) chk("run_busy", busy, 1'b1);
      end else begin
        chk("done_out_valid", out_valid, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_result", res, q[0].exp);
      end
      if (flush) void'(q.pop_front());
      else if (el >= q[0].lat && out_ready) void'(q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic rdy;
    int   guard;
    guard = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); guard++;
    end while (!rdy && guard < 100);
    chk("accept_ready", rdy, 1'b1);
    #1;
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output logic [W-1:0] r, output int n, input int hold);
    n = 0;
    out_ready = 1'b0;
    do begin @(posedge clk); n++; #1; end while (!out_valid && n < 100);
    chk("done_seen", out_valid, 1'b1);
    r = res;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_out_valid", out_valid, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]   t_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [W-1:0] t_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] t_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [W-1:0] t_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int           t_lat [12] = '{MLAT, MLAT, MLAT, MLAT, LAT, LAT, LAT, LAT, 1, 1, 1, 1};

  initial begin
    logic [W-1:0] r;
    int           n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: pin the model and check DUT result and latency
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("model%0d", i), model(t_op[i], t_a[i], t_b[i]), t_exp[i]);
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(r, n, 0);
      chk($sformatf("dir%0d_result", i), r, t_exp[i]);
      chk($sformatf("dir%0d_latency", i), 32'(n), 32'(t_lat[i]));
    end

    // Backpressure: result held for 10 cycles
    issue(3'd0, 32'd5, 32'd6);
    wait_done(r, n, 10);
    chk("bp_result", r, 32'd30);

    // Flush at iteration 5 of a divide, then a new op right away
    issue(3'd4, 32'h1234_5678, 32'd3);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    wait_done(r, n, 0);
    chk("post_flush_result", r, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a multiply
    issue(3'd1, 32'h7654_3210, 32'h0123_4567);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_result", res, '0);
    chk("arst_in_ready", in_ready, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd5, 32'd100, 32'd7);
    wait_done(r, n, 0);
    chk("post_rst_result", r, 32'd14);

    // Randomized operations checked by the compare process
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_done(r, n, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
